// File: rtl/pipeline_pkg.sv
// Shared encodings for the MIPS pipeline: load sizes and write-back source selects.
package pipeline_pkg;

    typedef enum logic [1:0] {
        BHW_BYTE = 2'b00,
        BHW_HALF = 2'b01,
        BHW_WORD = 2'b11
    } bhw_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wb_sel_e;

endpackage

// File: rtl/load_extender.sv
// Picks the byte/halfword lane of an aligned little-endian load word and sign/zero-extends it.
module load_extender
    import pipeline_pkg::*;
#(
    parameter int INST_SZ = 32
) (
    input  logic [INST_SZ-1:0] word,
    input  logic [1:0]         offset,
    input  logic [1:0]         bhw,
    input  logic               is_unsigned,
    output logic [INST_SZ-1:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_sign;
    logic        half_sign;

    // Halfword lane uses only offset[1]; encoding 2'b10 falls through to a full word.
    always_comb begin
        byte_lane = word[{offset, 3'b000} +: 8];
        half_lane = word[{offset[1], 4'b0000} +: 16];
        byte_sign = ~is_unsigned & byte_lane[7];
        half_sign = ~is_unsigned & half_lane[15];
        case (bhw)
            BHW_BYTE: ext = {{(INST_SZ-8){byte_sign}}, byte_lane};
            BHW_HALF: ext = {{(INST_SZ-16){half_sign}}, half_lane};
            default:  ext = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects write-back data, gates the register-file write,
// counts retired instructions and latches a sticky halt flag for the debug unit.
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int INST_SZ  = 32,
    parameter int REG_ADDR = 5,
    parameter int CNT_SZ   = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_valid_M,
    input  logic [INST_SZ-1:0]  i_alu_result_M,
    input  logic [INST_SZ-1:0]  i_read_data_M,
    input  logic [INST_SZ-1:0]  i_pc_8_M,
    input  logic [1:0]          i_bhw_M,
    input  logic                i_unsigned_M,
    input  logic [1:0]          i_wb_sel_M,
    input  logic                i_reg_write_M,
    input  logic [REG_ADDR-1:0] i_write_reg_M,
    input  logic                i_halt_M,
    output logic                o_valid_W,
    output logic                o_reg_write_W,
    output logic [REG_ADDR-1:0] o_write_reg_W,
    output logic [INST_SZ-1:0]  o_write_data_W,
    output logic [CNT_SZ-1:0]   o_retired_cnt,
    output logic                o_halt_W
);

    logic [INST_SZ-1:0] load_data;
    logic [INST_SZ-1:0] wb_data;
    logic               reg_write_ok;

    load_extender #(.INST_SZ(INST_SZ)) u_load_extender (
        .word        (i_read_data_M),
        .offset      (i_alu_result_M[1:0]),
        .bhw         (i_bhw_M),
        .is_unsigned (i_unsigned_M),
        .ext         (load_data)
    );

    // Writes to $0 are dropped here so the register file never sees them.
    always_comb begin
        reg_write_ok = i_reg_write_M & i_valid_M & (i_write_reg_M != '0);
        case (i_wb_sel_M)
            WB_MEM:  wb_data = load_data;
            WB_LINK: wb_data = i_pc_8_M;
            default: wb_data = i_alu_result_M;
        endcase
    end

    // Flush beats stall beats load; a flush keeps data/address but kills the slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_W      <= 1'b0;
            o_reg_write_W  <= 1'b0;
            o_write_reg_W  <= '0;
            o_write_data_W <= '0;
            o_retired_cnt  <= '0;
            o_halt_W       <= 1'b0;
        end else if (i_flush) begin
            o_valid_W     <= 1'b0;
            o_reg_write_W <= 1'b0;
        end else if (!i_stall) begin
            o_valid_W      <= i_valid_M;
            o_reg_write_W  <= reg_write_ok;
            o_write_reg_W  <= i_write_reg_M;
            o_write_data_W <= wb_data;
            if (i_valid_M) begin
                o_retired_cnt <= o_retired_cnt + CNT_SZ'(1);
            end
            if (i_valid_M && i_halt_M) begin
                o_halt_W <= 1'b1;
            end
        end
    end

endmodule
